writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback logic of the RISC-V core. Captures the
//  memory-stage result bundle, aligns and extends load data, selects the result and
//  drives the register-file write port (WE3/A3/WD3) one cycle later. Also drives the
//  WB->EX forwarding bypass, load-fault reporting and a 64-bit retired-instruction counter.
// PARAMETERS
//  XLEN       32  datapath width (only 32 is supported)
//  CNT_W      64  instret counter width
// PORTS
//  CLK            in   1     clock, all state updates on rising edge
//  areset         in   1     reset, synchronous, active-low
//  in_valid       in   1     memory-stage bundle valid this cycle
//  in_ready       out  1     stage accepts a bundle (= !hold)
//  hold           in   1     hazard-unit stall: freeze stage contents
//  flush          in   1     kill the bundle being captured this cycle
//  in_reg_write   in   1     instruction writes rd
//  in_rd          in   5     destination register
//  in_result_src  in   2     00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
//  in_funct3      in   3     load size/sign (used only when result_src=01)
//  in_alu_result  in   32    ALU result; also the load byte address
//  in_mem_rdata   in   32    raw aligned-word read data from data memory
//  in_pc_plus4    in   32    PC+4 for JAL/JALR
//  in_imm         in   32    immediate for LUI
//  WE3            out  1     register-file write enable
//  A3             out  5     register-file write address
//  WD3            out  32    register-file write data
//  wb_valid       out  1     stage holds a valid instruction
//  fwd_valid      out  1     bypass valid (= wb_valid & reg_write & rd!=0 & !fault)
//  fwd_rd         out  5     bypass register (= A3)
//  fwd_data       out  32    bypass data (= WD3)
//  wb_fault       out  1     load fault, 1-cycle pulse
//  wb_cause       out  2     01 misaligned load, 10 illegal load funct3, 00 none
//  instret        out  64    retired-instruction count
// BEHAVIOUR
//  - Reset (areset=0 at edge): all outputs/state 0, instret=0. Reset wins over everything.
//  - Capture edge: hold=0. flush=1 -> wb_valid<=0, WE3<=0, fault<=0 (flush beats in_valid).
//    Else wb_valid<=in_valid; A3, WD3, cause computed from inputs and registered. Latency 1.
//  - hold=1 (and no reset): every register keeps its value, except WE3<=0 and wb_fault<=0;
//    flush ignored while hold=1. WE3/wb_fault therefore pulse only once per instruction.
//  - Load extract, off=in_alu_result[1:0]: LB 000 / LBU 100 take byte off, sign/zero-ext;
//    LH 001 / LHU 101 take half off[1], sign/zero-ext; LW 010 whole word.
//  - Fault: LH/LHU with off[0]=1 or LW with off!=0 -> cause 01; funct3 011/110/111 -> 10.
//    Fault only when result_src=01 and in_valid. On fault: WE3=0, WD3=0, wb_fault=1 one cycle.
//  - WE3 = capture & in_valid & in_reg_write & in_rd!=0 & !fault. rd=x0 never writes.
//  - A3 = in_rd when captured valid, else 0. Fault status not counted as retired.
//  - instret += 1 on each capture edge with in_valid=1, no flush, no fault; wraps mod 2^64.
//  - Outputs are registered only; no combinational path from inputs to WE3/A3/WD3.
// TESTING
//  1 ALU: valid, src=00, rd=5, alu=0x1234 -> next cycle WE3=1,A3=5,WD3=0x1234,instret=1.
//  2 LB: src=01,f3=000,alu=0x...03,rdata=0x80FF_0000 -> WD3=0xFFFF_FF80; LBU -> 0x0000_0080.
//  3 LH at alu=0x...01 -> WE3=0, wb_fault=1, cause=01, instret unchanged; f3=110 -> cause=10.
//  4 hold for 3 cycles after ALU capture -> WE3 high 1 cycle only, A3/WD3/wb_valid held.
//  5 flush with in_valid=1 -> wb_valid=0, WE3=0; rd=0 reg_write=1 -> WE3=0, instret +1.
//  6 areset low mid-hold with instret=0xFFFF_FFFF_FFFF_FFFF -> all 0; wrap check pre-reset.

Source files
------------

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//   MEM/WB pipeline register plus writeback logic. Captures the memory-stage
//   result bundle, extracts and extends load data, selects the result and
//   drives the register-file write port one cycle later. Also provides the
//   WB->EX bypass, load-fault reporting and a retired-instruction counter.
//
// Handshake: a bundle is accepted on a rising edge when in_valid=1 and
//   in_ready=1. in_ready is simply !hold; while hold=1 nothing is accepted
//   and the stage contents are frozen. in_valid may change freely while
//   in_ready=0 because the stage does not look at it.
//
// Ports
//   CLK, areset           clock; synchronous active-low reset
//   in_valid/in_ready     bundle valid / stage accepts
//   hold, flush           freeze stage / kill the bundle being captured
//   in_reg_write, in_rd   destination write request and register
//   in_result_src         00 ALU, 01 load, 10 PC+4, 11 immediate
//   in_funct3             load size/sign
//   in_alu_result         ALU result, also load byte address
//   in_mem_rdata          raw aligned word from data memory
//   in_pc_plus4, in_imm   alternative result sources
//   WE3, A3, WD3          register-file write port (registered)
//   wb_valid              stage holds a valid instruction
//   fwd_valid/rd/data     WB->EX bypass
//   wb_fault, wb_cause    load fault pulse; 01 misaligned, 10 illegal funct3
//   instret               retired-instruction count
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             CLK,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  input  logic             flush,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_result_src,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  in_imm,
  output logic             WE3,
  output logic [4:0]       A3,
  output logic [XLEN-1:0]  WD3,
  output logic             wb_valid,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             wb_fault,
  output logic [1:0]       wb_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b10;

  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] result_d;
  logic [1:0]      cause_d;
  logic            fault_d;
  logic            rw_q;      // captured instruction requested a write

  assign in_ready = !hold;

  // Load extraction and fault classification
  always_comb begin
    off       = in_alu_result[1:0];
    byte_sel  = in_mem_rdata[{off, 3'b000} +: 8];
    half_sel  = off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    load_data = '0;
    cause_d   = CAUSE_NONE;
    case (in_funct3)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_data = {24'd0, byte_sel};
      3'b001: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        if (off[0]) cause_d = CAUSE_MISALIGN;
      end
      3'b101: begin
        load_data = {16'd0, half_sel};
        if (off[0]) cause_d = CAUSE_MISALIGN;
      end
      3'b010: begin
        load_data = in_mem_rdata;
        if (off != 2'b00) cause_d = CAUSE_MISALIGN;
      end
      default: cause_d = CAUSE_ILLEGAL;
    endcase
    // Faults only exist for a valid load; other sources ignore funct3.
    if (!(in_valid && in_result_src == SRC_LOAD)) cause_d = CAUSE_NONE;
    fault_d = (cause_d != CAUSE_NONE);

    case (in_result_src)
      SRC_ALU:  result_d = in_alu_result;
      SRC_LOAD: result_d = load_data;
      SRC_PC4:  result_d = in_pc_plus4;
      default:  result_d = in_imm;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!areset) begin
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      wb_valid <= 1'b0;
      wb_fault <= 1'b0;
      wb_cause <= CAUSE_NONE;
      rw_q     <= 1'b0;
      instret  <= '0;
    end else if (hold) begin
      // Frozen, but pulses drop so each instruction writes/faults once.
      WE3      <= 1'b0;
      wb_fault <= 1'b0;
    end else if (flush) begin
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      wb_valid <= 1'b0;
      wb_fault <= 1'b0;
      wb_cause <= CAUSE_NONE;
      rw_q     <= 1'b0;
    end else begin
      wb_valid <= in_valid;
      rw_q     <= in_valid & in_reg_write;
      A3       <= in_valid ? in_rd : 5'd0;
      WD3      <= (in_valid && !fault_d) ? result_d : '0;
      wb_cause <= cause_d;
      wb_fault <= fault_d;
      WE3      <= in_valid & in_reg_write & (in_rd != 5'd0) & !fault_d;
      if (in_valid && !fault_d) instret <= instret + CNT_W'(1);
    end
  end

  // wb_cause is held through a stall, so it marks a faulted instruction for
  // the bypass even after the wb_fault pulse has dropped.
  assign fwd_valid = wb_valid & rw_q & (A3 != 5'd0) & (wb_cause == CAUSE_NONE);
  assign fwd_rd    = A3;
  assign fwd_data  = WD3;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        CLK = 1'b0;
  logic        areset;
  logic        in_valid, in_ready, hold, flush, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_result_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        wb_valid, fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        wb_fault;
  logic [1:0]  wb_cause;
  logic [63:0] instret;

  writeback_stage dut (
    .CLK(CLK), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .flush(flush), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_result_src(in_result_src), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .WE3(WE3), .A3(A3), .WD3(WD3), .wb_valid(wb_valid),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_fault(wb_fault), .wb_cause(wb_cause), .instret(instret)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state (what the stage should hold after the edge)
  logic        e_valid, e_we, e_fault, e_rw;
  logic [4:0]  e_a3;
  logic [31:0] e_wd3;
  logic [1:0]  e_cause;
  logic [63:0] e_instret;

  // Load value from the architectural rules, using shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      3'd2:    return word;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_cause(input logic [2:0] f3,
                                           input logic [31:0] addr);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 2'd2;
    if ((f3 == 1 || f3 == 5) && (addr % 2) != 0) return 2'd1;
    if (f3 == 2 && (addr % 4) != 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the current inputs, then check.
  task automatic cycle();
    logic [1:0]  c;
    logic [31:0] r;
    if (!areset) begin
      e_valid = 0; e_we = 0; e_fault = 0; e_rw = 0;
      e_a3 = 0; e_wd3 = 0; e_cause = 0; e_instret = 0;
    end else if (hold) begin
      e_we = 0; e_fault = 0;
    end else if (flush) begin
      e_valid = 0; e_we = 0; e_fault = 0; e_rw = 0;
      e_a3 = 0; e_wd3 = 0; e_cause = 0;
    end else begin
      c = (in_valid && in_result_src == 2'd1) ? ref_cause(in_funct3, in_alu_result) : 2'd0;
      case (in_result_src)
        2'd0: r = in_alu_result;
        2'd1: r = ref_load(in_funct3, in_alu_result, in_mem_rdata);
        2'd2: r = in_pc_plus4;
        default: r = in_imm;
      endcase
      e_valid = in_valid;
      e_cause = c;
      e_fault = (c != 0);
      e_rw    = in_valid && in_reg_write;
      e_a3    = in_valid ? in_rd : 5'd0;
      e_wd3   = (in_valid && c == 0) ? r : 32'd0;
      e_we    = in_valid && in_reg_write && in_rd != 0 && c == 0;
      if (in_valid && c == 0) e_instret = e_instret + 1;
    end
    @(posedge CLK);
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, !hold});
    chk("we3", {63'd0, WE3}, {63'd0, e_we});
    chk("a3", {59'd0, A3}, {59'd0, e_a3});
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, e_valid});
    chk("wb_fault", {63'd0, wb_fault}, {63'd0, e_fault});
    chk("wb_cause", {62'd0, wb_cause}, {62'd0, e_cause});
    chk("instret", instret, e_instret);
    chk("fwd_valid", {63'd0, fwd_valid},
        {63'd0, e_valid && e_rw && e_a3 != 0 && e_cause == 0});
    chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, e_a3});
    if (e_valid) begin
      chk("wd3", {32'd0, WD3}, {32'd0, e_wd3});
      chk("fwd_data", {32'd0, fwd_data}, {32'd0, e_wd3});
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_result_src = src;
    in_funct3 = f3; in_alu_result = alu; in_mem_rdata = rdata;
    in_pc_plus4 = $urandom; in_imm = $urandom;
  endtask

  task automatic set_instret_ones();
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    e_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("instret_preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  initial begin
    areset = 0; hold = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    e_valid = 0; e_we = 0; e_fault = 0; e_rw = 0;
    e_a3 = 0; e_wd3 = 0; e_cause = 0; e_instret = 0;
    cycle(); cycle();
    areset = 1;

    // ALU writeback
    drive(1, 1, 5, 2'd0, 3'd0, 32'h1234, 32'h0);
    cycle();
    chk("alu_wd3_const", {32'd0, WD3}, 64'h1234);
    chk("alu_instret_const", instret, 64'd1);

    // hold three cycles: WE3 drops, rest frozen
    hold = 1;
    drive(1, 1, 9, 2'd0, 3'd0, 32'hDEAD, 32'h0);
    cycle(); cycle(); cycle();
    chk("hold_a3_const", {59'd0, A3}, 64'd5);
    hold = 0;

    // LB / LBU at byte 3
    drive(1, 1, 7, 2'd1, 3'b000, 32'h0000_1003, 32'h80FF_0000);
    cycle();
    chk("lb_const", {32'd0, WD3}, 64'hFFFF_FF80);
    drive(1, 1, 7, 2'd1, 3'b100, 32'h0000_1003, 32'h80FF_0000);
    cycle();
    chk("lbu_const", {32'd0, WD3}, 64'h0000_0080);

    // misaligned LH, then illegal funct3
    drive(1, 1, 8, 2'd1, 3'b001, 32'h0000_2001, 32'h1234_5678);
    cycle();
    chk("lh_mis_cause_const", {62'd0, wb_cause}, 64'd1);
    drive(1, 1, 8, 2'd1, 3'b110, 32'h0000_2000, 32'h1234_5678);
    cycle();
    chk("ill_cause_const", {62'd0, wb_cause}, 64'd2);
    // faulted instruction held: pulse drops, cause stays
    hold = 1; cycle(); hold = 0;

    // flush beats valid; rd=x0 counts but does not write
    flush = 1;
    drive(1, 1, 3, 2'd0, 3'd0, 32'h55, 32'h0);
    cycle();
    flush = 0;
    drive(1, 1, 0, 2'd0, 3'd0, 32'h77, 32'h0);
    cycle();
    // flush ignored while holding
    hold = 1; flush = 1; cycle(); hold = 0; flush = 0;

    // counter wrap
    set_instret_ones();
    drive(1, 1, 4, 2'd2, 3'd0, 32'h0, 32'h0);
    cycle();
    chk("wrap_const", instret, 64'd0);

    // reset in the middle of a hold with a full counter
    set_instret_ones();
    hold = 1;
    cycle();
    areset = 0;
    cycle();
    chk("reset_instret_const", instret, 64'd0);
    areset = 1; hold = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom, $urandom);
      hold   = ($urandom_range(0, 4) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      areset = ($urandom_range(0, 99) != 0);
      cycle();
    end
    areset = 1; hold = 0; flush = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
